// File: rtl/alu_scan_display_if.sv
// rtl/alu_scan_display_if.sv - board-side signal bundle for the ALU scan display
//
// Purpose: groups the switch/button inputs and the display/LED outputs of
// alu_scan_display so the board wrapper and the bench connect through one port.
// Ports (signals):
//   sw    2*WIDTH  {B, A} operand switches
//   btnU  1        mode-advance button, active-high, asynchronous
//   an    DIGITS   anode enables, active-low
//   seg   7        segments GFEDCBA, active-low
//   dp    1        decimal point, active-low
//   led   2        {zero, carry}, active-high
// Modports: master drives sw/btnU (board or bench), slave is the display core.
interface alu_scan_display_if #(
  parameter int WIDTH = 4
);
  localparam int DIGITS = 3 * (WIDTH / 4) + 1;

  logic [2*WIDTH-1:0] sw;
  logic               btnU;
  logic [DIGITS-1:0]  an;
  logic [6:0]         seg;
  logic               dp;
  logic [1:0]         led;

  modport master (output sw, output btnU, input an, input seg, input dp, input led);
  modport slave  (input sw, input btnU, output an, output seg, output dp, output led);
endinterface

// File: rtl/alu_scan_display.sv
// rtl/alu_scan_display.sv - four-operation ALU with multiplexed hex display
//
// Purpose: samples operands A/B from the switches, computes ADD/SUB/AND/XOR
// selected by a button-stepped mode, and scans A, B, the result and the mode
// digit onto an active-low seven-segment display. The carry/borrow is shown
// on the mode digit's decimal point and on led[0]; led[1] flags a zero result.
// Ports:
//   clk     system clock, rising edge
//   btnC_n  asynchronous active-low reset
//   bus     alu_scan_display_if slave: sw, btnU in; an, seg, dp, led out
module alu_scan_display #(
  parameter int WIDTH     = 4,
  parameter int DIVIDE_BY = 1
) (
  input  logic                 clk,
  input  logic                 btnC_n,
  alu_scan_display_if.slave    bus
);

  localparam int NIB    = WIDTH / 4;
  localparam int DIGITS = 3 * NIB + 1;
  localparam int IDXW   = $clog2(DIGITS);
  localparam int PW     = $clog2(2 * DIVIDE_BY);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);
  localparam logic [IDXW-1:0] MODE_IDX = IDXW'(3 * NIB);
  localparam logic [PW-1:0]   PTERM    = PW'(2 * DIVIDE_BY - 1);

  logic [WIDTH-1:0]  r_a, r_b, r_res;
  logic              r_carry, r_zero;
  logic [1:0]        r_mode;
  logic              r_sync1, r_sync2, r_sync3;
  logic [1:0]        r_vld;
  logic              r_armed;
  logic [PW-1:0]     r_presc;
  logic [IDXW-1:0]   r_idx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic [WIDTH:0]    w_sum, w_diff;
  logic [WIDTH-1:0]  w_res;
  logic              w_carry;
  logic              w_rise;
  logic [4*DIGITS-1:0] w_disp;
  logic [3:0]        w_nib;

  function automatic logic [6:0] f_glyph(input logic [3:0] n);
    case (n)
      4'h0: f_glyph = 7'b1000000;
      4'h1: f_glyph = 7'b1111001;
      4'h2: f_glyph = 7'b0100100;
      4'h3: f_glyph = 7'b0110000;
      4'h4: f_glyph = 7'b0011001;
      4'h5: f_glyph = 7'b0010010;
      4'h6: f_glyph = 7'b0000010;
      4'h7: f_glyph = 7'b1111000;
      4'h8: f_glyph = 7'b0000000;
      4'h9: f_glyph = 7'b0010000;
      4'hA: f_glyph = 7'b0001000;
      4'hB: f_glyph = 7'b0000011;
      4'hC: f_glyph = 7'b1000110;
      4'hD: f_glyph = 7'b0100001;
      4'hE: f_glyph = 7'b0000110;
      default: f_glyph = 7'b0001110;
    endcase
  endfunction

  // The synchroniser flops reset to 0, which looks like a released button.
  // r_vld marks when r_sync2 holds a genuine sample, and r_armed only sets
  // once that genuine sample is low, so a button held through reset release
  // never counts as a press.
  assign w_rise = r_sync2 & ~r_sync3 & r_armed;

  always_comb begin
    w_sum   = {1'b0, r_a} + {1'b0, r_b};
    w_diff  = {1'b0, r_a} - {1'b0, r_b};
    w_res   = '0;
    w_carry = 1'b0;
    case (r_mode)
      2'd0: begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
      2'd1: begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
      2'd2: w_res = r_a & r_b;
      default: w_res = r_a ^ r_b;
    endcase
  end

  // Digit index 0 is the rightmost anode: A nibbles, then B, then R, then mode.
  assign w_disp = {2'b00, r_mode, r_res, r_b, r_a};

  always_comb begin
    w_nib = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDXW'(k)) w_nib = w_disp[4*k +: 4];
    end
  end

  always_ff @(posedge clk or negedge btnC_n) begin
    if (!btnC_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_mode  <= 2'd0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= '1;
      r_seg   <= 7'b1111111;
      r_dp    <= 1'b1;
    end else begin
      r_a     <= bus.sw[WIDTH-1:0];
      r_b     <= bus.sw[2*WIDTH-1:WIDTH];
      r_res   <= w_res;
      r_carry <= w_carry;
      r_zero  <= (w_res == '0);

      r_sync1 <= bus.btnU;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_sync2) r_armed <= 1'b1;
      if (w_rise) r_mode <= r_mode + 2'd1;

      if (r_presc == PTERM) begin
        r_presc <= '0;
        r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IDXW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= f_glyph(w_nib);
      r_dp  <= ~((r_idx == MODE_IDX) && r_carry);
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;
  assign bus.led = {r_zero, r_carry};

endmodule

// File: tb/tb_alu_scan_display.sv
// tb/tb_alu_scan_display.sv - self-checking bench for alu_scan_display
module tb_alu_scan_display;

  logic clk = 1'b0;
  logic btnC_n = 1'b0;
  always #5 clk = ~clk;

  alu_scan_display_if #(.WIDTH(4)) bus4 ();
  alu_scan_display_if #(.WIDTH(8)) bus8 ();

  alu_scan_display #(.WIDTH(4), .DIVIDE_BY(1)) dut4 (.clk(clk), .btnC_n(btnC_n), .bus(bus4.slave));
  alu_scan_display #(.WIDTH(8), .DIVIDE_BY(3)) dut8 (.clk(clk), .btnC_n(btnC_n), .bus(bus8.slave));

  int n_vec = 0;
  int n_err = 0;
  int m4 = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // {an, seg, dp} packed into one int: an << 8 | seg << 1 | dp
  function automatic int obs(input int sel);
    if (sel == 0) return (int'(bus4.an) << 8) | (int'(bus4.seg) << 1) | int'(bus4.dp);
    return (int'(bus8.an) << 8) | (int'(bus8.seg) << 1) | int'(bus8.dp);
  endfunction

  function automatic void model(input int w, input int a, input int b, input int m,
                                output int r, output int carry, output int zero);
    int mask;
    mask = (1 << w) - 1;
    carry = 0;
    case (m)
      0: begin r = (a + b) & mask; carry = ((a + b) > mask) ? 1 : 0; end
      1: begin r = (a - b) & mask; carry = (a < b) ? 1 : 0; end
      2: r = a & b;
      default: r = a ^ b;
    endcase
    zero = (r == 0) ? 1 : 0;
  endfunction

  // Syncs to the start of digit 0 and checks one full scan cycle by cycle.
  task automatic scan_check(input int sel, input int a, input int b, input int m, input string tag);
    int w, hold, n, digits, r, carry, zero, d0, cur, prev, k, val, expv, ledv;
    bit found;
    w = (sel == 0) ? 4 : 8;
    hold = (sel == 0) ? 2 : 6;
    n = w / 4;
    digits = 3 * n + 1;
    model(w, a, b, m, r, carry, zero);
    d0 = (~1) & ((1 << digits) - 1);
    found = 0;
    prev = obs(sel) >> 8;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      cur = obs(sel) >> 8;
      if (cur == d0 && prev != d0) found = 1;
      else prev = cur;
    end
    if (!found) begin
      check({tag, "_sync"}, 0, 1);
      return;
    end
    for (int c = 0; c < digits * hold; c++) begin
      if (c > 0) cycle();
      k = c / hold;
      if (k < n) val = (a >> (4 * k)) & 15;
      else if (k < 2 * n) val = (b >> (4 * (k - n))) & 15;
      else if (k < 3 * n) val = (r >> (4 * (k - 2 * n))) & 15;
      else val = m;
      expv = (((~(1 << k)) & ((1 << digits) - 1)) << 8) | (int'(glyph_tab[val]) << 1)
             | ((k == 3 * n && carry == 1) ? 0 : 1);
      check($sformatf("%s_d%0d", tag, k), obs(sel), expv);
    end
    ledv = (sel == 0) ? int'(bus4.led) : int'(bus8.led);
    check({tag, "_led"}, ledv, (zero << 1) | carry);
  endtask

  task automatic pulse();
    bus4.btnU = 1'b1;
    repeat (3) cycle();
    bus4.btnU = 1'b0;
    repeat (3) cycle();
    m4 = (m4 + 1) % 4;
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 4 && m4 != target; i++) pulse();
  endtask

  task automatic apply4(input int a, input int b, input string tag);
    bus4.sw = 8'((b << 4) | a);
    repeat (4) cycle();
    scan_check(0, a, b, m4, tag);
  endtask

  initial begin
    int a, b, np;
    bit hit;
    bus4.sw = '0;
    bus4.btnU = 1'b0;
    bus8.sw = '0;
    bus8.btnU = 1'b0;

    // Reset values and first scan after release
    repeat (3) cycle();
    check("rst_an", int'(bus4.an), 'hF);
    check("rst_seg", int'(bus4.seg), 'h7F);
    check("rst_dp", int'(bus4.dp), 1);
    check("rst_led", int'(bus4.led), 0);
    check("rst_an8", int'(bus8.an), 'h7F);
    btnC_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      check($sformatf("rel_c%0d", c), obs(0),
            ((((~(1 << (c / 2))) & 'hF)) << 8) | (int'(glyph_tab[0]) << 1) | 1);
    end

    // Exhaustive ADD
    for (int i = 0; i < 256; i++) apply4(i & 15, i >> 4, $sformatf("add_%02h", i));

    // Mode stepping with A=3, B=5
    pulse();
    apply4(3, 5, "step_sub");
    pulse();
    apply4(3, 5, "step_and");
    pulse();
    apply4(3, 5, "step_xor");
    pulse();
    apply4(3, 5, "step_add");

    // Held button: exactly one increment
    bus4.btnU = 1'b1;
    repeat (50) cycle();
    bus4.btnU = 1'b0;
    repeat (4) cycle();
    m4 = (m4 + 1) % 4;
    apply4(3, 5, "held");

    // SUB zero and borrow
    goto_mode(1);
    apply4(7, 7, "sub_zero");
    apply4(0, 1, "sub_borrow");
    apply4(15, 0, "sub_max");

    // Randomized operands and mode steps, sw change coinciding with btnU rise
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      np = $urandom_range(0, 2);
      bus4.sw = 8'((b << 4) | a);
      for (int p = 0; p < np; p++) pulse();
      repeat (2) cycle();
      scan_check(0, a, b, m4, $sformatf("rnd%0d", i));
    end

    // Wider build
    bus8.sw = 16'hA53C;
    repeat (4) cycle();
    scan_check(1, 'h3C, 'hA5, 0, "w8_fixed");
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      bus8.sw = 16'((b << 8) | a);
      repeat (4) cycle();
      scan_check(1, a, b, 0, $sformatf("w8_rnd%0d", i));
    end

    // Reset mid-scan with btnU held through release
    goto_mode(2);
    bus4.sw = 8'h53;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      cycle();
      if (bus4.an == 4'b1011) hit = 1;
    end
    check("mid_find_idx2", int'(hit), 1);
    bus4.btnU = 1'b1;
    cycle();
    btnC_n = 1'b0;
    #1;
    check("mid_rst_an", int'(bus4.an), 'hF);
    check("mid_rst_seg", int'(bus4.seg), 'h7F);
    check("mid_rst_led", int'(bus4.led), 0);
    repeat (3) cycle();
    btnC_n = 1'b1;
    m4 = 0;
    cycle();
    check("mid_first_an", int'(bus4.an), 'hE);
    repeat (30) cycle();
    scan_check(0, 3, 5, m4, "mid_held");
    bus4.btnU = 1'b0;
    repeat (4) cycle();
    pulse();
    apply4(3, 5, "mid_rearm");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
